// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared constants and FSM state encoding for the sequential
//                restoring divider (seq_divider and its step datapath).
//                DIV_WL : dividend width (always 2*DIV_WS)
//                DIV_WS : divisor / quotient / remainder width, and the
//                         number of restoring iterations
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WS = 16;
    localparam int DIV_WL = 2 * DIV_WS;

    // FSM encoding (IDLE, RUN, DONE)
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : div_pkg
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_if
//  Description : Operand and result handshake bundle for seq_divider.
//                Operand side : in_valid, in_ready, dividend[WL], divisor[WS]
//                Result side  : out_valid, out_ready, quotient[WS],
//                               remainder[WS], ovf, div0
//                master : the agent issuing operands and consuming results
//                slave  : the divider
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WL = DIV_WL,
    parameter int WS = DIV_WS
);

    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] dividend;
    logic [WS-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [WS-1:0] quotient;
    logic [WS-1:0] remainder;
    logic          ovf;
    logic          div0;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, div0
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, div0
    );

endinterface : seq_divider_if
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division step.
//                r      [WS+1] : partial remainder in
//                q      [WS]   : dividend-low / quotient shift register in
//                v      [WS]   : divisor
//                r_next [WS+1] : partial remainder out
//                q_next [WS]   : shift register out, new quotient bit in LSB
//  Revision    : 1.0  initial release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WS = DIV_WS
) (
    input  wire logic [WS:0]   r,
    input  wire logic [WS-1:0] q,
    input  wire logic [WS-1:0] v,
    output logic      [WS:0]   r_next,
    output logic      [WS-1:0] q_next
);

    logic [WS:0] w_t;
    logic        w_bit;

    // Shift the next dividend bit into the partial remainder.
    assign w_t = {r[WS-1:0], q[WS-1]};

    // r[WS] would be the bit shifted out of w_t; if it were ever set the
    // true trial value exceeds V, so it forces a subtract. With R < V
    // maintained it is always 0 and this reduces to the plain compare.
    assign w_bit  = r[WS] || (w_t >= {1'b0, v});
    assign r_next = w_bit ? (w_t - {1'b0, v}) : w_t;
    assign q_next = {q[WS-2:0], w_bit};

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Sequential restoring divider, WL-bit dividend by WS-bit
//                divisor (WL must equal 2*WS), one quotient bit per cycle.
//                clk : clock, rising edge
//                rst : asynchronous active-high reset
//                bus : seq_divider_if.slave (operand and result handshakes)
//                Latency accept->out_valid: WS+1 cycles normal, 1 cycle for
//                overflow or divide-by-zero.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WL = DIV_WL,
    parameter int WS = DIV_WS
) (
    input  wire logic    clk,
    input  wire logic    rst,
    seq_divider_if.slave bus
);

    localparam int            CW      = $clog2(WS);
    localparam logic [CW-1:0] C_LAST  = CW'(WS - 1);
    localparam logic [WS-1:0] C_ONES  = {WS{1'b1}};

    state_t        r_state;
    logic [WL-1:0] r_d;          // latched dividend
    logic [WS-1:0] r_v;          // latched divisor
    logic [WS:0]   r_rem;        // partial remainder
    logic [WS-1:0] r_q;          // dividend-low / quotient shift register
    logic [CW-1:0] r_cnt;
    logic [WS-1:0] r_quotient;
    logic [WS-1:0] r_remainder;
    logic          r_ovf;
    logic          r_div0;

    logic [WS:0]   w_r_next;
    logic [WS-1:0] w_q_next;

    div_step #(
        .WS (WS)
    ) u_step (
        .r      (r_rem),
        .q      (r_q),
        .v      (r_v),
        .r_next (w_r_next),
        .q_next (w_q_next)
    );

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.ovf       = r_ovf;
    assign bus.div0      = r_div0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_d         <= '0;
            r_v         <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ovf       <= 1'b0;
            r_div0      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_d <= bus.dividend;
                        r_v <= bus.divisor;
                        if (bus.divisor == '0) begin
                            r_div0      <= 1'b1;
                            r_ovf       <= 1'b0;
                            r_quotient  <= C_ONES;
                            r_remainder <= '0;
                            r_state     <= ST_DONE;
                        end else if (bus.dividend[WL-1:WS] >= bus.divisor) begin
                            // Quotient would need more than WS bits.
                            r_ovf       <= 1'b1;
                            r_div0      <= 1'b0;
                            r_quotient  <= C_ONES;
                            r_remainder <= '0;
                            r_state     <= ST_DONE;
                        end else begin
                            r_rem   <= {1'b0, bus.dividend[WL-1:WS]};
                            r_q     <= bus.dividend[WS-1:0];
                            r_cnt   <= '0;
                            r_state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    r_rem <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        // Final step: publish straight from the step outputs.
                        r_quotient  <= w_q_next;
                        r_remainder <= w_r_next[WS-1:0];
                        r_ovf       <= 1'b0;
                        r_div0      <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Reconstruction check: quotient*divisor + remainder == dividend.
    logic [WL-1:0] w_recon;
    assign w_recon = ({{(WL-WS){1'b0}}, r_quotient} * {{(WL-WS){1'b0}}, r_v})
                   + {{(WL-WS){1'b0}}, r_remainder};

    ap_recon : assert property (
        @(posedge clk) disable iff (rst)
        (bus.out_valid && !r_ovf && !r_div0) |-> ((w_recon == r_d) && (r_remainder < r_v))
    );

endmodule : seq_divider
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider. It is the inverse datapath of the team's WL-bit product multiplier.
- Takes a WL-bit dividend (typically a product) and a WS-bit divisor. Returns a WS-bit quotient and a WS-bit remainder.
- Uses valid/ready handshakes on both input and output.
- Sits downstream of the multiplier benches. Carries an embedded reconstruction property for model checking.

Parameters:
- WL, 32, dividend width; must equal 2*WS.
- WS, 16, divisor/quotient/remainder width; also the iteration count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider can accept operands.
- dividend  in  WL  numerator.
- divisor  in  WS  denominator.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  WS  result quotient.
- remainder  out  WS  result remainder.
- ovf  out  1  quotient does not fit in WS bits (divisor nonzero).
- div0  out  1  divisor was zero.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; ovf=0; div0=0; iteration counter=0; operand regs=0.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE). A transfer occurs on a cycle where in_valid && in_ready.
- IDLE, on accept: latch dividend into D and divisor into V.
  - If divisor==0: div0=1, ovf=0, quotient=all ones, remainder=0 -> DONE.
  - Else if dividend[WL-1:WS] >= divisor: ovf=1, div0=0, quotient=all ones, remainder=0 -> DONE.
  - Else: partial remainder R (WS+1 bits) = dividend[WL-1:WS]; Q = dividend[WS-1:0]; cnt=0 -> RUN.
- RUN, each cycle, one restoring step:
  - T = {R[WS-1:0], Q[WS-1]}.
  - If T >= {0,V}: R = T - V and the new quotient bit is 1. Else R = T and the bit is 0.
  - Q shifts left with the new bit in the LSB. cnt increments.
  - When cnt==WS-1 the step completes, then go DONE.
- Result invariant: R < V always holds, so R[WS] is 0 at exit. remainder = R[WS-1:0].
- DONE: out_valid=1; quotient, remainder, ovf and div0 are held stable until out_valid && out_ready. Then go IDLE with out_valid=0.
  - Result registers retain their last values after the handshake; only out_valid drops.
- Latency, accept edge to out_valid high:
  - Normal case: WS+1 cycles (17 at default).
  - ovf/div0 case: 1 cycle.
- Throughput: one operation per WS+2 cycles with out_ready tied high.
  - in_ready stays low during DONE, so there is no accept on the cycle the result is consumed. The next accept comes one cycle later.
- Backpressure: out_ready low holds DONE indefinitely. No state changes and no new accepts.
- in_valid during RUN/DONE is ignored; operands are not sampled.
- Reset mid-RUN or mid-DONE aborts the operation. The pending result is lost and no out_valid is produced.
- Embedded property, checked when out_valid && !ovf && !div0: quotient*divisor_latched + remainder == dividend_latched (WL-bit arithmetic), and remainder < divisor_latched.

Decomposition:
- Package div_pkg: WL/WS constants and the state enum (IDLE, RUN, DONE).
- Combinational sub-module div_step: inputs R, Q, V; outputs next R, next Q. Instantiated once in the RUN datapath.
- Handshake/FSM and result registers stay in seq_divider.

Test Plan:
- 100 / 7, out_ready=1 -> quotient=14, remainder=2, ovf=0, div0=0; out_valid exactly 17 cycles after accept, high for 1 cycle.
- 0xFFFE0001 / 0xFFFF -> quotient=0xFFFF, remainder=0. Then 0xFFFEFFFF / 0xFFFF -> quotient=0xFFFF, remainder=0xFFFE (max non-overflow cases).
- 0x00010000 / 0x0001 -> ovf=1, quotient=0xFFFF, remainder=0, out_valid 1 cycle after accept. Then 1234 / 0 -> div0=1, ovf=0.
- 1000 / 3 with out_ready=0 for 10 cycles after out_valid -> outputs stable at 333/1; in_ready=0 throughout, and a second in_valid is ignored. Raise out_ready -> handshake; in_ready=1 the next cycle.
- Accept 500/9, assert rst at cycle 5 of RUN -> all outputs 0 immediately, no out_valid. Then 500/9 -> quotient=55, remainder=5 with normal 17-cycle latency.
- Random back-to-back operands with random out_ready: every result satisfies the reconstruction property, and the accept count equals the result count.
